// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: RX pin, runtime configuration, FIFO pop port and status of the UART receiver.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic             rx;
    logic [DIV_W-1:0] baud_div;
    logic             par_en;
    logic             par_odd;
    logic             ien;
    logic             ack;
    logic             rd_en;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             busy;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;
    logic             irq;
    modport master (
        output rx, baud_div, par_en, par_odd, ien, ack, rd_en,
        input  rd_data, rd_valid, count, busy, frame_err, parity_err, overrun, irq
    );
    modport slave (
        input  rx, baud_div, par_en, par_odd, ien, ack, rd_en,
        output rd_data, rd_valid, count, busy, frame_err, parity_err, overrun, irq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver with majority vote, optional parity,
// sticky error flags, interrupt and a first-word fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input logic          clk,
    input logic          rst,
    uart_rx_fifo_if.slave u
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state;
    logic                 s1, s2, prev;
    logic [DIV_W-1:0]     div_q, divcnt;
    logic [3:0]           os;
    logic [1:0]           smp;
    logic [DATA_BITS-1:0] sh;
    logic [BW-1:0]        bitn;
    logic                 par_bad;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [AW:0]          cnt;
    logic                 fe_q, pe_q, ov_q, irq_q;
    logic                 start_edge, tick, vote, dec, last, full, pop;
    logic                 stop_dec, good, push, fe_set, pe_set, ov_set;
    logic [7:0]           wdata;
    always_comb begin
        start_edge = prev & ~s2;
        tick       = divcnt == div_q;
        vote       = (smp[0] & smp[1]) | (smp[0] & s2) | (smp[1] & s2);
        dec        = tick && os == 4'd9;
        last       = tick && os == 4'd15;
        full       = cnt == (AW+1)'(FIFO_DEPTH);
        pop        = u.rd_en && cnt != '0;
        stop_dec   = state == STOP && dec;
        good       = stop_dec && vote && !par_bad;
        push       = good && (!full || pop);
        fe_set     = stop_dec && !vote;
        pe_set     = stop_dec && par_bad;
        ov_set     = good && full && !pop;
        wdata      = '0;
        wdata[DATA_BITS-1:0] = sh;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s1      <= 1'b1;
            s2      <= 1'b1;
            prev    <= 1'b1;
            div_q   <= '0;
            divcnt  <= '0;
            os      <= '0;
            smp     <= '0;
            sh      <= '0;
            bitn    <= '0;
            par_bad <= 1'b0;
        end else begin
            s1   <= u.rx;
            s2   <= s1;
            prev <= s2;
            if (state == IDLE) begin
                divcnt <= '0;
                os     <= '0;
                if (start_edge) begin
                    state   <= START;
                    div_q   <= u.baud_div;
                    bitn    <= '0;
                    par_bad <= 1'b0;
                end
            end else begin
                divcnt <= tick ? '0 : divcnt + 1'b1;
                if (tick) os <= os + 1'b1;
                if (tick && os == 4'd7) smp[0] <= s2;
                if (tick && os == 4'd8) smp[1] <= s2;
                case (state)
                    START: state <= (dec && vote) ? IDLE : last ? DATA : START;
                    DATA: begin
                        if (dec) sh <= {vote, sh[DATA_BITS-1:1]};
                        if (last) begin
                            bitn <= bitn + 1'b1;
                            if (bitn == BW'(DATA_BITS-1)) state <= u.par_en ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (dec) par_bad <= vote != (^sh ^ u.par_odd);
                        if (last) state <= STOP;
                    end
                    STOP: if (dec) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    // a new set beats a simultaneous ack clear
    always_ff @(posedge clk) begin
        if (rst) begin
            fe_q  <= 1'b0;
            pe_q  <= 1'b0;
            ov_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            fe_q  <= fe_set || (fe_q && !u.ack);
            pe_q  <= pe_set || (pe_q && !u.ack);
            ov_q  <= ov_set || (ov_q && !u.ack);
            irq_q <= (u.ien && (push || fe_set || pe_set || ov_set)) || (irq_q && !u.ack);
        end
    end
    assign u.rd_valid   = cnt != '0;
    assign u.rd_data    = u.rd_valid ? mem[rp] : 8'h00;
    assign u.count      = cnt;
    assign u.busy       = state != IDLE;
    assign u.frame_err  = fe_q;
    assign u.parity_err = pe_q;
    assign u.overrun    = ov_q;
    assign u.irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into an 8-bit and a 7-bit receiver (both 4-deep FIFO, baud_div=3),
// expected values computed by hand.
module tb_uart_rx_fifo;
    localparam int BIT = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic busy_c2, busy_c3;
    always #5 clk = ~clk;
    uart_rx_fifo_if #(.FIFO_DEPTH(4), .DIV_W(16)) ia ();
    uart_rx_fifo_if #(.FIFO_DEPTH(4), .DIV_W(16)) ib ();
    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut_a (.clk(clk), .rst(rst), .u(ia.slave));
    uart_rx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_W(16)) dut_b (.clk(clk), .rst(rst), .u(ib.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // frame = start, data LSB first, optional parity, stop, one idle bit; ack pulses at cycle ack_at
    task automatic send(input bit sel, input logic [7:0] d, input int nb, input bit pe, input bit pb,
                        input bit sb, input int ack_at);
        logic [11:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nb; i++) f[1+i] = d[i];
        n = 1 + nb;
        if (pe) begin
            f[n] = pb;
            n++;
        end
        f[n] = sb;
        n += 2;
        for (int c = 0; c < n * BIT; c++) begin
            if (c == 2) busy_c2 = sel ? ib.busy : ia.busy;
            if (c == 3) busy_c3 = sel ? ib.busy : ia.busy;
            if (sel) begin
                ib.rx  = f[c/BIT];
                ib.ack = (c == ack_at);
            end else begin
                ia.rx  = f[c/BIT];
                ia.ack = (c == ack_at);
            end
            @(negedge clk);
        end
        ia.ack = 1'b0;
        ib.ack = 1'b0;
    endtask

    task automatic pulse_ack(input bit sel);
        if (sel) ib.ack = 1'b1; else ia.ack = 1'b1;
        @(negedge clk);
        ia.ack = 1'b0;
        ib.ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        chk(tag, ia.rd_data, exp);
        ia.rd_en = 1'b1;
        @(negedge clk);
        ia.rd_en = 1'b0;
    endtask

    initial begin
        ia.rx = 1'b1; ia.baud_div = 16'd3; ia.par_en = 1'b0; ia.par_odd = 1'b0;
        ia.ien = 1'b1; ia.ack = 1'b0; ia.rd_en = 1'b0;
        ib.rx = 1'b1; ib.baud_div = 16'd3; ib.par_en = 1'b1; ib.par_odd = 1'b0;
        ib.ien = 1'b1; ib.ack = 1'b0; ib.rd_en = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", ia.busy, 0);
        chk("rst_valid", ia.rd_valid, 0);
        chk("rst_count", ia.count, 0);
        chk("rst_data", ia.rd_data, 0);
        chk("rst_flags", {ia.frame_err, ia.parity_err, ia.overrun}, 0);
        chk("rst_irq", ia.irq, 0);

        send(0, 8'hA5, 8, 0, 0, 1, -1);
        chk("lat_busy_c2", busy_c2, 0);
        chk("lat_busy_c3", busy_c3, 1);
        chk("a5_data", ia.rd_data, 8'hA5);
        chk("a5_valid", ia.rd_valid, 1);
        chk("a5_count", ia.count, 1);
        chk("a5_flags", {ia.frame_err, ia.parity_err, ia.overrun}, 0);
        chk("a5_busy", ia.busy, 0);
        chk("a5_irq", ia.irq, 1);
        pulse_ack(0);
        chk("a5_irq_ack", ia.irq, 0);
        chk("a5_count_ack", ia.count, 1);
        pop_a("a5_pop", 8'hA5);
        chk("a5_empty", ia.rd_valid, 0);

        send(1, 8'h35, 7, 1, 0, 1, -1);
        chk("p_data", ib.rd_data, 8'h35);
        chk("p_count", ib.count, 1);
        chk("p_perr", ib.parity_err, 0);
        pulse_ack(1);
        chk("p_irq_ack", ib.irq, 0);
        send(1, 8'h35, 7, 1, 1, 1, -1);
        chk("pbad_count", ib.count, 1);
        chk("pbad_perr", ib.parity_err, 1);
        chk("pbad_irq", ib.irq, 1);
        chk("pbad_ferr", ib.frame_err, 0);

        send(0, 8'h3C, 8, 0, 0, 0, -1);
        chk("fe_flag", ia.frame_err, 1);
        chk("fe_count", ia.count, 0);
        send(0, 8'h5A, 8, 0, 0, 1, -1);
        chk("fe_next_data", ia.rd_data, 8'h5A);
        chk("fe_next_count", ia.count, 1);
        chk("fe_sticky", ia.frame_err, 1);
        pulse_ack(0);
        chk("fe_ack", ia.frame_err, 0);
        pop_a("fe_pop", 8'h5A);

        send(0, 8'h11, 8, 0, 0, 1, -1);
        send(0, 8'h22, 8, 0, 0, 1, -1);
        send(0, 8'h33, 8, 0, 0, 1, -1);
        send(0, 8'h44, 8, 0, 0, 1, -1);
        chk("ov_pre", ia.overrun, 0);
        send(0, 8'h55, 8, 0, 0, 1, -1);
        chk("ov_count", ia.count, 4);
        chk("ov_flag", ia.overrun, 1);
        pop_a("ov_pop1", 8'h11);
        pop_a("ov_pop2", 8'h22);
        pop_a("ov_pop3", 8'h33);
        chk("ov_count1", ia.count, 1);
        pop_a("ov_pop4", 8'h44);
        chk("ov_count0", ia.count, 0);
        ia.rd_en = 1'b1;
        @(negedge clk);
        ia.rd_en = 1'b0;
        @(negedge clk);
        chk("under_count", ia.count, 0);
        chk("under_valid", ia.rd_valid, 0);
        pulse_ack(0);
        chk("ov_ack", ia.overrun, 0);

        ia.rx = 1'b0;
        repeat (4) @(negedge clk);
        ia.rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("gl_busy", ia.busy, 0);
        chk("gl_count", ia.count, 0);
        chk("gl_flags", {ia.frame_err, ia.parity_err, ia.overrun}, 0);
        chk("gl_irq", ia.irq, 0);

        send(0, 8'hC3, 8, 0, 0, 0, 618);
        chk("ackc_ferr", ia.frame_err, 1);
        chk("ackc_irq", ia.irq, 1);
        chk("ackc_count", ia.count, 0);
        pulse_ack(0);
        chk("ackc_clear", ia.frame_err, 0);

        send(0, 8'h66, 8, 0, 0, 1, -1);
        send(0, 8'h77, 8, 0, 0, 1, -1);
        chk("rst_pre_count", ia.count, 2);
        ia.rx = 1'b0;
        repeat (BIT + 100) @(negedge clk);
        chk("rst_mid_busy", ia.busy, 1);
        rst = 1'b1;
        ia.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT) @(negedge clk);
        chk("rst_mid_count", ia.count, 0);
        chk("rst_mid_idle", ia.busy, 0);
        chk("rst_mid_valid", ia.rd_valid, 0);
        chk("rst_mid_flags", {ia.frame_err, ia.parity_err, ia.overrun, ia.irq}, 0);
        send(0, 8'h96, 8, 0, 0, 1, -1);
        chk("post_rst_data", ia.rd_data, 8'h96);
        chk("post_rst_count", ia.count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, a runtime baud divisor, optional parity, and a receive FIFO with error reporting. It sits between the board RX pin and the memory-mapped UART peripheral on the core bus. It supersedes the single-byte receiver: the CPU drains bytes through a pop interface instead of reading one holding register, and interrupt acknowledge no longer stalls reception.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..8; unused upper rd_data bits read 0
- FIFO_DEPTH, 16, receive FIFO entries, power of two, at least 2
- DIV_W, 16, width of baud_div
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high
- rx  in  1  asynchronous serial input, idle high
- baud_div  in  DIV_W  oversample tick period minus 1; one tick every baud_div+1 clocks
- par_en  in  1  parity bit present after the data bits
- par_odd  in  1  1 selects odd parity, 0 selects even
- ien  in  1  interrupt enable
- ack  in  1  one-cycle pulse; clears irq and all sticky error flags
- rd_en  in  1  pop the FIFO head; ignored when the FIFO is empty
- rd_data  out  8  FIFO head, first-word fall-through
- rd_valid  out  1  FIFO not empty
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  state != IDLE
- frame_err  out  1  sticky: stop bit sampled 0
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: good frame dropped because the FIFO was full
- irq  out  1  interrupt request

## Operation
- rx passes through a 2-FF synchronizer, both FFs reset to 1, followed by a previous-value register for edge detection.
- Tick generator:
  - divcnt counts 0..div_q; tick is asserted when divcnt == div_q.
  - div_q latches baud_div on each start edge, so a baud_div change takes effect at the next frame.
  - In IDLE, divcnt is held at 0.
- Oversample counter os runs 0..15 and advances on each tick. One bit lasts 16 ticks.
  - The three samples taken at os = 7, 8 and 9 are majority-voted.
  - The bit decision is made on the tick with os == 9.
  - The bit ends on the tick with os == 15.
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE: a synchronized 1->0 transition resets divcnt and os, latches div_q, and moves to START.
- START:
  - Voted 0: continue to DATA at the end of the bit.
  - Voted 1: false start; return to IDLE at the decision tick. No flag is set.
- DATA:
  - DATA_BITS bits are shifted in LSB first.
  - After the last bit, go to PARITY if par_en, otherwise to STOP.
- PARITY: expected bit = XOR of the data bits XOR par_odd. A mismatch marks the frame bad.
- STOP: at the decision tick, return to IDLE immediately. The remaining half bit is not waited for, which allows resync on back-to-back frames.
  - Stop voted 0: set frame_err, discard the byte. A new start needs rx to return to 1 first.
  - Parity bad: set parity_err, discard the byte. If both errors occur, set both flags.
  - Good frame with the FIFO not full, or full while rd_en pops in the same cycle: push the byte, zero-extended.
  - Good frame with the FIFO full and no pop: set overrun, drop the new byte, leave FIFO contents unchanged.
- FIFO:
  - Circular buffer with wrapping read and write pointers.
  - Push and pop in the same cycle leave count unchanged.
  - rd_en while empty has no effect, and count never underflows.
- irq:
  - Set on a cycle with ien = 1 and either a push or a new error-flag set.
  - Cleared by ack. If set and ack coincide, set wins.
  - ien = 0 does not clear an already-set irq.
- ack:
  - Clears frame_err, parity_err, overrun and irq.
  - An error set in the ack cycle wins over the clear.
  - ack does not affect the receive state machine or the FIFO.

## Timing
- Reset values:
  - state = IDLE, FIFO empty, count = 0, rd_valid = 0, rd_data = 0.
  - All error flags = 0, irq = 0, busy = 0, synchronizer = 1.
- rst mid-frame aborts the frame with no push and no flag, and empties the FIFO.
- Start latency: busy rises 3 clocks after the rx falling edge (2 synchronizer cycles plus 1 edge-detect cycle).
- Bit period is 16*(baud_div+1) clocks. Sample points are 8/16 of a bit after the synchronized edge, ±1 tick.
- Push to output: rd_valid, rd_data and count update 1 clock after the stop-bit decision tick. irq and error flags also update in that same cycle.
- Pop: on the clock edge where rd_en = 1 and rd_valid = 1, the next entry appears on rd_data the following cycle.

## Test plan
- baud_div=3, 8N1, send 0xA5 → one push; rd_data=0xA5; rd_valid=1; count=1; no error flags; busy low after the stop decision.
- DATA_BITS=7, par_en=1, par_odd=0, send 0x35 with correct parity → rd_data=0x35. Repeat with the parity bit flipped → no push, parity_err=1, irq=1 (ien=1).
- Frame with stop bit 0 → frame_err=1, count unchanged. A following good 0x5A is received correctly once rx idles high.
- FIFO_DEPTH=4, send 5 bytes without reading → count=4, overrun=1, FIFO holds bytes 1-4. Pop all 4 in order, then rd_en while empty → count stays 0.
- A 1-tick low glitch on rx in IDLE → START aborts, no push, no flag. Separately, ack in the same cycle as a new error → the flag stays 1.
- rst asserted mid-byte with 2 bytes queued → count=0, state IDLE. The next full frame is received normally.
